// File: rtl/caravel_pkg.sv
// caravel_pkg: shared SPI opcodes, FSM states and default parameters for the caravel boot streamer
package caravel_pkg;
  localparam logic [7:0] OP_WAKE = 8'hAB;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam int START_DELAY_DEF = 12500;
  localparam int HOLD_CYCLES_DEF = 256;
  localparam int MAX_BYTES_DEF = 256;
  typedef enum logic [2:0] {IDLE_WAIT, WAKE, GAP, CMD, ADDR, READ, HOLD, DONE} state_e;
endpackage

// File: rtl/caravel_spi_byte_xfer.sv
// spi_byte_xfer: mode-0 SPI byte exchange at clk/2, MSB first, start/busy/done handshake
module spi_byte_xfer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] tx_byte_i,
  input  logic       miso_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] rx_byte_o,
  output logic       sclk_o,
  output logic       mosi_o
);
  logic       busy_q, busy_d, sclk_q, sclk_d, done_q, done_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] tx_q, tx_d, rx_q, rx_d;
  // MISO is captured while sclk is high; the falling edge and next MOSI bit share that clock edge
  always_comb begin
    busy_d = busy_q;
    sclk_d = sclk_q;
    cnt_d  = cnt_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    done_d = 1'b0;
    if (!busy_q) begin
      busy_d = start_i;
      tx_d   = start_i ? tx_byte_i : tx_q;
    end else if (!sclk_q) begin
      sclk_d = 1'b1;
    end else begin
      sclk_d = 1'b0;
      rx_d   = {rx_q[6:0], miso_i};
      tx_d   = {tx_q[6:0], 1'b0};
      cnt_d  = cnt_q + 3'd1;
      busy_d = cnt_q != 3'd7;
      done_d = cnt_q == 3'd7;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
    end else begin
      busy_q <= busy_d;
      sclk_q <= sclk_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
    end
  end
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rx_byte_o = rx_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = tx_q[7];
endmodule

// File: rtl/caravel.sv
// caravel: boots from SPI flash and streams bytes onto mprj_io[7:0], each held for HOLD_CYCLES
module caravel import caravel_pkg::*; #(
  parameter int START_DELAY = START_DELAY_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int MAX_BYTES   = MAX_BYTES_DEF
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        vddio,
  input  logic        vddio_2,
  input  logic        vssio,
  input  logic        vssio_2,
  input  logic        vdda,
  input  logic        vssa,
  input  logic        vccd,
  input  logic        vssd,
  input  logic        vdda1,
  input  logic        vdda1_2,
  input  logic        vdda2,
  input  logic        vssa1,
  input  logic        vssa1_2,
  input  logic        vssa2,
  input  logic        vccd1,
  input  logic        vccd2,
  input  logic        vssd1,
  input  logic        vssd2,
  inout  wire  [37:0] mprj_io,
  inout  wire         gpio,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1
);
  localparam int DW = $clog2(START_DELAY) + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int BW = $clog2(MAX_BYTES) + 1;
  localparam logic [DW-1:0] D_LAST    = DW'(START_DELAY - 1);
  localparam logic [HW-1:0] H_LAST    = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] GAP_LAST  = HW'(3);
  localparam logic [HW-1:0] ADDR_LAST = HW'(2);
  localparam logic [BW-1:0] B_MAX     = BW'(MAX_BYTES);
  state_e        state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          oe_q, oe_d;
  logic [7:0]    disp_q, disp_d;
  logic          xfer, start, busy, done, unused_pwr;
  logic [7:0]    tx, rx;
  assign unused_pwr = ^{vddio, vddio_2, vssio, vssio_2, vdda, vssa, vccd, vssd, vdda1, vdda1_2,
                        vdda2, vssa1, vssa1_2, vssa2, vccd1, vccd2, vssd1, vssd2};
  // The boot read stays parked (csb low, clock low) until the pads are enabled
  assign xfer  = state_q inside {WAKE, CMD, ADDR, READ};
  assign start = xfer && !busy && !done && (state_q != READ || oe_q);
  assign tx    = state_q == WAKE ? OP_WAKE : state_q == CMD ? OP_READ : 8'h00;
  spi_byte_xfer u_spi (
    .clk(clock), .rst(resetb), .start_i(start), .tx_byte_i(tx), .miso_i(flash_io1),
    .busy_o(busy), .done_o(done), .rx_byte_o(rx), .sclk_o(flash_clk), .mosi_o(flash_io0)
  );
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bcnt_d  = bcnt_q;
    disp_d  = disp_q;
    dcnt_d  = oe_q ? dcnt_q : dcnt_q + DW'(1);
    oe_d    = oe_q || dcnt_q == D_LAST;
    case (state_q)
      IDLE_WAIT: state_d = WAKE;
      WAKE:      state_d = done ? GAP : WAKE;
      GAP: begin
        hcnt_d  = hcnt_q == GAP_LAST ? '0 : hcnt_q + HW'(1);
        state_d = hcnt_q == GAP_LAST ? CMD : GAP;
      end
      CMD:       state_d = done ? ADDR : CMD;
      ADDR: if (done) begin
        hcnt_d  = hcnt_q == ADDR_LAST ? '0 : hcnt_q + HW'(1);
        state_d = hcnt_q == ADDR_LAST ? READ : ADDR;
      end
      READ: if (done) begin
        disp_d  = rx;
        bcnt_d  = bcnt_q + BW'(1);
        state_d = HOLD;
      end
      HOLD: begin
        hcnt_d  = hcnt_q == H_LAST ? '0 : hcnt_q + HW'(1);
        state_d = hcnt_q != H_LAST ? HOLD : (disp_q == 8'h00 || bcnt_q == B_MAX) ? DONE : READ;
      end
      DONE:      state_d = DONE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (resetb) begin
      state_q <= IDLE_WAIT;
      dcnt_q  <= '0;
      hcnt_q  <= '0;
      bcnt_q  <= '0;
      oe_q    <= 1'b0;
      disp_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      hcnt_q  <= hcnt_d;
      bcnt_q  <= bcnt_d;
      oe_q    <= oe_d;
      disp_q  <= disp_d;
    end
  end
  assign flash_csb      = !(state_q inside {WAKE, CMD, ADDR, READ, HOLD});
  assign mprj_io[37:8]  = 'z;
  assign mprj_io[7:0]   = oe_q ? disp_q : 'z;
  assign gpio           = state_q == DONE;
endmodule

// File: tb/tb_caravel.sv
// tb_caravel: flash model plus scoreboard checking the streamed display bytes and SPI bus sequence
`timescale 1ns/1ps
module tb_caravel;
  localparam int SD = 200, HC = 16, MB = 256;
  logic clock = 1'b0, resetb = 1'b1, flash_io1 = 1'b0, pull = 1'b0;
  logic flash_csb, flash_clk, flash_io0;
  wire [37:0] mprj_io;
  wire gpio;
  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] mem [0:511];
  logic [7:0] cmd [0:3];
  logic [7:0] sh;
  logic [7:0] exp_q [$];
  logic [7:0] seq [0:11] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'hFF, 8'h00};
  int nbit = 0, txn = 0, nbytes = 0, seen = 0, cd = 0, last_cyc = 0, clk_viol = 0, nb0;
  logic in_txn = 1'b0, first_in_run = 1'b1;
  realtime t_rise = 0, t_edge = 0;

  assign mprj_io[3] = pull ? 1'b1 : 1'bz;

  caravel #(.START_DELAY(SD), .HOLD_CYCLES(HC), .MAX_BYTES(MB)) dut (
    .clock(clock), .resetb(resetb),
    .vddio(1'b1), .vddio_2(1'b1), .vssio(1'b0), .vssio_2(1'b0), .vdda(1'b1), .vssa(1'b0),
    .vccd(1'b1), .vssd(1'b0), .vdda1(1'b1), .vdda1_2(1'b1), .vdda2(1'b1), .vssa1(1'b0),
    .vssa1_2(1'b0), .vssa2(1'b0), .vccd1(1'b1), .vccd2(1'b1), .vssd1(1'b0), .vssd2(1'b0),
    .mprj_io(mprj_io), .gpio(gpio), .flash_csb(flash_csb), .flash_clk(flash_clk),
    .flash_io0(flash_io0), .flash_io1(flash_io1)
  );

  always #12.5 clock = ~clock;
  initial forever begin @(posedge clock); cyc++; end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // flash model: bus sequence checks and read data driven on the falling sclk edge
  initial forever begin
    @(negedge flash_csb);
    nbit = 0;
    in_txn = 1'b1;
    if (txn == 1) chk("wake_gap_ge4", ($realtime - t_rise) >= 99.0, 1);
  end
  initial forever begin
    @(posedge flash_csb);
    if (in_txn) begin
      in_txn = 1'b0;
      t_rise = $realtime;
      if (txn == 0) begin
        chk("wake_len", nbit, 8);
        chk("wake_op", cmd[0], 8'hAB);
      end else if (txn == 1) begin
        chk("read_hdr", {cmd[0], cmd[1], cmd[2], cmd[3]}, 32'h03000000);
        chk("read_len", nbit >= 32, 1);
      end
      txn++;
    end
  end
  initial forever begin
    @(posedge flash_clk);
    if (!flash_csb) begin
      sh = {sh[6:0], flash_io0};
      nbit++;
      if (nbit <= 32 && nbit % 8 == 0) cmd[nbit/8-1] = sh;
      if (nbit > 32 && nbit % 8 == 0) nbytes++;
    end
  end
  initial forever begin
    @(negedge flash_clk);
    if (!flash_csb && nbit >= 32) flash_io1 = mem[(nbit-32)/8][7 - (nbit-32)%8];
  end
  initial forever begin
    @(flash_clk);
    if (!flash_csb && ($realtime - t_edge) < 24.0) clk_viol++;
    t_edge = $realtime;
  end

  // scoreboard monitor: a byte completed on the bus must be on the pads two clocks later
  initial forever begin
    @(posedge clock); #1;
    if (cd != 0) begin
      cd--;
      if (cd == 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL disp_unexpected: got %0h expected none", mprj_io[7:0]);
        end else chk("disp", {24'h0, mprj_io[7:0]}, {24'h0, exp_q.pop_front()});
        if (!first_in_run) chk("hold_len", (cyc - last_cyc) >= HC, 1);
        first_in_run = 1'b0;
        last_cyc = cyc;
      end
    end
    if (nbytes != seen) begin
      seen = nbytes;
      cd = 2;
    end
  end

  task automatic reset_run();
    @(negedge clock);
    resetb = 1'b1;
    pull = 1'b1;
    repeat (3) @(negedge clock);
    txn = 0;
    first_in_run = 1'b1;
    resetb = 1'b0;
    repeat (SD - 3) @(posedge clock);
    #1;
    chk("pull_bit3", mprj_io[3], 1);
    chk("gpio_early", gpio, 0);
    pull = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("oe_zero", mprj_io[7:0], 8'h00);
  endtask

  task automatic wait_done(input int lim, input logic [7:0] last);
    int n = 0;
    while (gpio !== 1'b1 && n < lim) begin
      @(posedge clock); #1;
      n++;
    end
    chk("gpio_done", gpio, 1);
    chk("done_after_hold", cyc - last_cyc, HC);
    chk("final_disp", mprj_io[7:0], last);
    chk("done_csb", flash_csb, 1);
    chk("done_clk", flash_clk, 0);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h55;
    for (int i = 0; i < 12; i++) mem[i] = seq[i];
    for (int i = 0; i < 12; i++) exp_q.push_back(seq[i]);
    reset_run();
    wait_done(3000, 8'h00);
    for (int i = 0; i < 4; i++) exp_q.push_back(seq[i]);
    reset_run();
    begin
      int n = 0;
      while (nbit < 68 && n < 3000) begin
        @(posedge clock); #1;
        n++;
      end
    end
    chk("fifth_read", nbit >= 68, 1);
    @(negedge clock);
    resetb = 1'b1;
    @(posedge clock); #1;
    chk("abort_csb", flash_csb, 1);
    chk("abort_clk", flash_clk, 0);
    chk("abort_gpio", gpio, 0);
    chk("abort_queue", exp_q.size(), 0);
    for (int i = 0; i < 12; i++) exp_q.push_back(seq[i]);
    reset_run();
    wait_done(3000, 8'h00);
    for (int i = 0; i < 512; i++) mem[i] = 8'hFF;
    for (int i = 0; i < MB; i++) exp_q.push_back(8'hFF);
    nb0 = nbytes;
    reset_run();
    wait_done(MB * (HC + 25) + 1000, 8'hFF);
    chk("ff_count", nbytes - nb0, MB);
    for (int i = 0; i < 512; i++) mem[i] = 8'h55;
    mem[0] = 8'h00;
    exp_q.push_back(8'h00);
    nb0 = nbytes;
    reset_run();
    wait_done(1000, 8'h00);
    chk("zero_count", nbytes - nb0, 1);
    chk("sclk_rate", clk_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
